bus_mem_slave: RTL and testbench



---
 rtl/bus_mem_slave_if.sv | 40 ++++
 rtl/bus_mem_slave.sv | 164 ++++++++++++++++
 tb/tb_bus_mem_slave.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_mem_slave_if.sv
// bus_mem_slave_if: one request/response channel between the CPU bus controller and a memory target.
// master drives BUS_valid/mode/addr/wdata/rready; slave drives BUS_wready/rvalid/rdata and bus_err.
interface bus_mem_slave_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  BUS_valid;
    logic                  BUS_mode;
    logic [ADDR_WIDTH-1:0] BUS_addr;
    logic [DATA_WIDTH-1:0] BUS_wdata;
    logic                  BUS_rready;
    logic                  BUS_wready;
    logic                  BUS_rvalid;
    logic [DATA_WIDTH-1:0] BUS_rdata;
    logic                  bus_err;

    modport master (
        output BUS_valid,
        output BUS_mode,
        output BUS_addr,
        output BUS_wdata,
        output BUS_rready,
        input  BUS_wready,
        input  BUS_rvalid,
        input  BUS_rdata,
        input  bus_err
    );

    modport slave (
        input  BUS_valid,
        input  BUS_mode,
        input  BUS_addr,
        input  BUS_wdata,
        input  BUS_rready,
        output BUS_wready,
        output BUS_rvalid,
        output BUS_rdata,
        output bus_err
    );
endinterface

// File: rtl/bus_mem_slave.sv
// bus_mem_slave: word-addressed single-port memory target with programmable wait states.
// Ports: clk, rst (async, active-high), bus_if (slave side of bus_mem_slave_if).
module bus_mem_slave #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    bus_mem_slave_if.slave bus_if
);
    localparam int         IDX_W   = $clog2(MEM_WORDS);
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_WRESP,
        S_RRESP,
        S_RELEASE
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  mode_q, mode_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  inr_q, inr_d;
    logic                  wready_q, wready_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic                  launch;
    logic                  mem_we;
    logic [IDX_W-1:0]      bus_idx;
    logic                  bus_inr;

    logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

    assign bus_idx = bus_if.BUS_addr[IDX_W+1:2];
    // In range when no address bit above the word index is set.
    assign bus_inr = (bus_if.BUS_addr >> (IDX_W + 2)) == '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mode_q   <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
            inr_q    <= 1'b0;
            wready_q <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            inr_q    <= inr_d;
            wready_q <= wready_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Storage is neither reset nor initialised.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx_d] <= wdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        inr_d    = inr_q;
        wready_d = 1'b0;
        rvalid_d = 1'b0;
        rdata_d  = '0;
        err_d    = 1'b0;
        mem_we   = 1'b0;
        launch   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus_if.BUS_valid) begin
                    mode_d  = bus_if.BUS_mode;
                    idx_d   = bus_idx;
                    wdata_d = bus_if.BUS_wdata;
                    inr_d   = bus_inr;
                    cnt_d   = WAIT_LD;
                    if (WAIT_CYCLES == 0) begin
                        launch = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!bus_if.BUS_valid) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q <= 4'd1) begin
                    launch = 1'b1;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_WRESP: begin
                state_d = S_RELEASE;
            end
            S_RRESP: begin
                if (!bus_if.BUS_valid) begin
                    state_d = S_IDLE;
                end else if (bus_if.BUS_rready) begin
                    state_d = S_RELEASE;
                end else begin
                    rvalid_d = 1'b1;
                    rdata_d  = rdata_q;
                end
            end
            S_RELEASE: begin
                // Hold here until the master lets go, so a held
                // request cannot be serviced a second time.
                if (!bus_if.BUS_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Response launch uses the request fields as they will be
        // latched (straight from the bus when there are no wait states).
        if (launch) begin
            err_d = ~inr_d;
            if (mode_d) begin
                state_d  = S_WRESP;
                wready_d = 1'b1;
                mem_we   = inr_d & ~rst;
            end else begin
                state_d  = S_RRESP;
                rvalid_d = 1'b1;
                rdata_d  = inr_d ? mem_q[idx_d] : '0;
            end
        end
    end

    assign bus_if.BUS_wready = wready_q;
    assign bus_if.BUS_rvalid = rvalid_q;
    assign bus_if.BUS_rdata  = rdata_q;
    assign bus_if.bus_err    = err_q;
endmodule

// File: tb/tb_bus_mem_slave.sv
// tb_bus_mem_slave: random and directed transfers on two slaves (2 and 0 wait states)
// against a transaction-level memory model.
module tb_bus_mem_slave;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int WORDS = 1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // sel = 1 routes the master to the zero-wait slave, 0 to the two-wait one.
    logic          sel;
    logic          drv_valid;
    logic          drv_mode;
    logic [AW-1:0] drv_addr;
    logic [DW-1:0] drv_wdata;
    logic          drv_rready;

    bus_mem_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus2 ();
    bus_mem_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();

    bus_mem_slave #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .MEM_WORDS(WORDS), .WAIT_CYCLES(2)
    ) u_dut2 (
        .clk(clk), .rst(rst), .bus_if(bus2.slave)
    );

    bus_mem_slave #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .MEM_WORDS(WORDS), .WAIT_CYCLES(0)
    ) u_dut0 (
        .clk(clk), .rst(rst), .bus_if(bus0.slave)
    );

    assign bus2.BUS_valid  = drv_valid & ~sel;
    assign bus2.BUS_mode   = drv_mode;
    assign bus2.BUS_addr   = drv_addr;
    assign bus2.BUS_wdata  = drv_wdata;
    assign bus2.BUS_rready = drv_rready & ~sel;
    assign bus0.BUS_valid  = drv_valid & sel;
    assign bus0.BUS_mode   = drv_mode;
    assign bus0.BUS_addr   = drv_addr;
    assign bus0.BUS_wdata  = drv_wdata;
    assign bus0.BUS_rready = drv_rready & sel;

    logic          obs_wready;
    logic          obs_rvalid;
    logic [DW-1:0] obs_rdata;
    logic          obs_err;
    assign obs_wready = sel ? bus0.BUS_wready : bus2.BUS_wready;
    assign obs_rvalid = sel ? bus0.BUS_rvalid : bus2.BUS_rvalid;
    assign obs_rdata  = sel ? bus0.BUS_rdata  : bus2.BUS_rdata;
    assign obs_err    = sel ? bus0.bus_err    : bus2.bus_err;

    // Reference memories: only words written in range are known.
    logic [DW-1:0] mdl0 [int];
    logic [DW-1:0] mdl2 [int];

    int checks;
    int failures;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic bit in_range(input logic [AW-1:0] a);
        return a < AW'(WORDS * 4);
    endfunction

    function automatic int word_of(input logic [AW-1:0] a);
        return int'((a >> 2) % AW'(WORDS));
    endfunction

    function automatic int wait_states();
        return sel ? 0 : 2;
    endfunction

    // A request accepted in cycle 0 responds in cycle wait_states()+1.
    task automatic txn(input bit m, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input int rdly,
                       input int hold, input bit early_rdy);
        int            w;
        bit            inr;
        int            ix;
        bit            known;
        logic [DW-1:0] exp;
        logic [DW-1:0] first;
        w   = wait_states();
        inr = in_range(a);
        ix  = word_of(a);
        drv_valid  = 1'b1;
        drv_mode   = m;
        drv_addr   = a;
        drv_wdata  = d;
        drv_rready = early_rdy;
        for (int k = 1; k <= w; k++) begin
            cyc();
            check("wait_wready", obs_wready, 0);
            check("wait_rvalid", obs_rvalid, 0);
        end
        cyc();
        if (m) begin
            check("wready", obs_wready, 1);
            check("werr", obs_err, 32'(!inr));
            check("w_no_rvalid", obs_rvalid, 0);
            if (inr) begin
                if (sel) mdl0[ix] = d;
                else     mdl2[ix] = d;
            end
            cyc();
            check("wready_pulse", obs_wready, 0);
            check("werr_pulse", obs_err, 0);
        end else begin
            known = 1'b1;
            exp   = '0;
            if (inr) begin
                if (sel) begin
                    known = mdl0.exists(ix);
                    if (known) exp = mdl0[ix];
                end else begin
                    known = mdl2.exists(ix);
                    if (known) exp = mdl2[ix];
                end
            end
            check("rvalid", obs_rvalid, 1);
            check("rerr", obs_err, 32'(!inr));
            if (known) check("rdata", obs_rdata, exp);
            first = obs_rdata;
            if (!early_rdy) begin
                for (int i = 0; i < rdly; i++) begin
                    cyc();
                    check("rvalid_hold", obs_rvalid, 1);
                    check("rdata_hold", obs_rdata, first);
                    check("rerr_once", obs_err, 0);
                end
                drv_rready = 1'b1;
            end
            cyc();
            check("rvalid_drop", obs_rvalid, 0);
            check("rdata_zero", obs_rdata, 0);
        end
        drv_rready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            cyc();
            check("held_wready", obs_wready, 0);
            check("held_rvalid", obs_rvalid, 0);
        end
        drv_valid = 1'b0;
        cyc();
    endtask

    // Write to the two-wait slave, withdrawn after one wait cycle.
    task automatic abort_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        drv_valid = 1'b1;
        drv_mode  = 1'b1;
        drv_addr  = a;
        drv_wdata = d;
        cyc();
        drv_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("abort_wready", obs_wready, 0);
            check("abort_err", obs_err, 0);
        end
    endtask

    // Read withdrawn while its data is being offered.
    task automatic abort_read(input logic [AW-1:0] a);
        int w;
        w = wait_states();
        drv_valid  = 1'b1;
        drv_mode   = 1'b0;
        drv_addr   = a;
        drv_rready = 1'b0;
        for (int k = 0; k <= w; k++) cyc();
        check("ab_rvalid", obs_rvalid, 1);
        cyc();
        check("ab_rvalid_hold", obs_rvalid, 1);
        drv_valid = 1'b0;
        cyc();
        check("ab_rvalid_drop", obs_rvalid, 0);
        check("ab_rdata_zero", obs_rdata, 0);
    endtask

    task automatic reset_in_read(input logic [AW-1:0] a);
        int w;
        w = wait_states();
        drv_valid  = 1'b1;
        drv_mode   = 1'b0;
        drv_addr   = a;
        drv_rready = 1'b0;
        for (int k = 0; k <= w; k++) cyc();
        check("rst_pre_rvalid", obs_rvalid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_rvalid", obs_rvalid, 0);
        check("rst_rdata", obs_rdata, 0);
        check("rst_err", obs_err, 0);
        drv_valid = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();
        check("rst_after_rvalid", obs_rvalid, 0);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        sel        = 1'b0;
        rst        = 1'b1;
        drv_valid  = 1'b0;
        drv_mode   = 1'b0;
        drv_addr   = '0;
        drv_wdata  = '0;
        drv_rready = 1'b0;
        repeat (3) cyc();
        check("rst_wready2", bus2.BUS_wready, 0);
        check("rst_rvalid2", bus2.BUS_rvalid, 0);
        check("rst_rdata2", bus2.BUS_rdata, 0);
        check("rst_err2", bus2.bus_err, 0);
        check("rst_wready0", bus0.BUS_wready, 0);
        check("rst_rvalid0", bus0.BUS_rvalid, 0);
        rst = 1'b0;
        cyc();

        sel = 1'b0;
        txn(1'b1, 32'h10, 32'hA5A5_1234, 0, 0, 1'b0);
        txn(1'b0, 32'h10, '0, 5, 0, 1'b0);
        txn(1'b1, 32'h0, 32'h1111_2222, 0, 1, 1'b0);
        txn(1'b1, 32'h1000, 32'hDEAD_BEEF, 0, 0, 1'b0);
        txn(1'b0, 32'h1000, '0, 1, 0, 1'b0);
        txn(1'b0, 32'h0, '0, 0, 0, 1'b1);

        sel = 1'b1;
        txn(1'b1, 32'h10, 32'h55AA_0FF0, 0, 3, 1'b0);
        txn(1'b0, 32'h10, '0, 0, 2, 1'b1);
        txn(1'b0, 32'h13, '0, 2, 0, 1'b0);
        txn(1'b1, 32'h1004, 32'h0BAD_0BAD, 0, 1, 1'b0);
        txn(1'b0, 32'h1004, '0, 0, 0, 1'b0);
        abort_read(32'h10);

        sel = 1'b0;
        txn(1'b1, 32'h20, 32'hCAFE_F00D, 0, 0, 1'b0);
        abort_write(32'h20, 32'h0BAD_BAD0);
        txn(1'b0, 32'h20, '0, 0, 0, 1'b0);
        abort_read(32'h20);

        for (int n = 0; n < 80; n++) begin
            logic [AW-1:0] a;
            sel = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                a = 32'h1000 + 32'($urandom_range(0, 255));
            end else begin
                a = 32'($urandom_range(0, 63)) * 4
                    + 32'($urandom_range(0, 3));
            end
            txn(1'($urandom_range(0, 1)), a, 32'($urandom()),
                $urandom_range(0, 3), $urandom_range(0, 2),
                1'($urandom_range(0, 1)));
        end

        sel = 1'b0;
        reset_in_read(32'h1000);
        reset_in_read(32'h10);
        txn(1'b0, 32'h10, '0, 0, 0, 1'b0);
        txn(1'b0, 32'h20, '0, 0, 0, 1'b0);
        sel = 1'b1;
        txn(1'b0, 32'h10, '0, 1, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
